// File: rtl/fpd_pkg.sv
// Shared definitions for the FFT peak detector: bin geometry, magnitude
// width, FSM state type and a helper that splits a packed bin into its
// real and imaginary fields.
package fpd_pkg;

  localparam int NUM_BINS = 16;
  localparam int IDX_W    = 4;
  localparam int MAG_W    = 32;
  localparam int COMP_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fpd_state_t;

  typedef struct packed {
    logic signed [COMP_W-1:0] re;
    logic signed [COMP_W-1:0] im;
  } fpd_bin_t;

  // Packed bin layout: [31:16] real, [15:0] imaginary.
  function automatic fpd_bin_t fpd_unpack(input logic [2*COMP_W-1:0] bin);
    fpd_bin_t b;
    b.re = bin[2*COMP_W-1:COMP_W];
    b.im = bin[COMP_W-1:0];
    return b;
  endfunction

endpackage

// File: rtl/fpd_mag_sq.sv
// Squared magnitude of one complex bin: re^2 + im^2, unsigned result.
// The largest result, 2 * (-2^(DATA_W-1))^2 = 2^(2*DATA_W-1), fits in
// 2*DATA_W unsigned bits, so the sum needs no extra carry bit.
module fpd_mag_sq #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   re_i,
  input  logic signed [DATA_W-1:0]   im_i,
  output logic        [2*DATA_W-1:0] mag_o
);

  logic signed [2*DATA_W-1:0] re_x;
  logic signed [2*DATA_W-1:0] im_x;
  logic signed [2*DATA_W-1:0] re_sq;
  logic signed [2*DATA_W-1:0] im_sq;

  // Sign-extend, square each component, then add as unsigned.
  always_comb begin
    re_x  = (2*DATA_W)'(re_i);
    im_x  = (2*DATA_W)'(im_i);
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    mag_o = $unsigned(re_sq) + $unsigned(im_sq);
  end

endmodule

// File: rtl/fft_peak_detect.sv
// FFT peak detector: captures 16 complex bins on fft_valid, walks them one
// per cycle through a single squarer pair, and reports the index of the
// strongest bin on freq with a one-cycle done strobe, 17 cycles after the
// frame was sampled. Ties resolve to the lowest index.
// Build option: define FPD_SKIP_DC_EN to exclude bin 0 from the search
// (search then starts from max_idx = 1, so an all-zero frame reports 1).
module fft_peak_detect
  import fpd_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_valid,
  input  logic [2*DATA_W-1:0]   fft_d0,
  input  logic [2*DATA_W-1:0]   fft_d1,
  input  logic [2*DATA_W-1:0]   fft_d2,
  input  logic [2*DATA_W-1:0]   fft_d3,
  input  logic [2*DATA_W-1:0]   fft_d4,
  input  logic [2*DATA_W-1:0]   fft_d5,
  input  logic [2*DATA_W-1:0]   fft_d6,
  input  logic [2*DATA_W-1:0]   fft_d7,
  input  logic [2*DATA_W-1:0]   fft_d8,
  input  logic [2*DATA_W-1:0]   fft_d9,
  input  logic [2*DATA_W-1:0]   fft_d10,
  input  logic [2*DATA_W-1:0]   fft_d11,
  input  logic [2*DATA_W-1:0]   fft_d12,
  input  logic [2*DATA_W-1:0]   fft_d13,
  input  logic [2*DATA_W-1:0]   fft_d14,
  input  logic [2*DATA_W-1:0]   fft_d15,
  output logic [IDX_W-1:0]      freq,
  output logic                  done,
  output logic                  busy,
  output logic                  ovf
);

  localparam int BIN_W = 2 * DATA_W;

`ifdef FPD_SKIP_DC_EN
  localparam bit SKIP_DC = 1'b1;
`else
  localparam bit SKIP_DC = 1'b0;
`endif

  localparam logic [IDX_W-1:0] START_IDX = SKIP_DC ? IDX_W'(1) : '0;

  logic [BIN_W-1:0] bins_in [NUM_BINS];
  logic [BIN_W-1:0] frame_q [NUM_BINS];

  fpd_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BIN_W-1:0] max_mag_q, max_mag_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W-1:0] freq_q, freq_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             load;

  logic [BIN_W-1:0]         cur_bin;
  logic signed [DATA_W-1:0] cur_re;
  logic signed [DATA_W-1:0] cur_im;
  logic [BIN_W-1:0]         cur_mag;
  logic                     cmp_en;

  assign bins_in[0]  = fft_d0;
  assign bins_in[1]  = fft_d1;
  assign bins_in[2]  = fft_d2;
  assign bins_in[3]  = fft_d3;
  assign bins_in[4]  = fft_d4;
  assign bins_in[5]  = fft_d5;
  assign bins_in[6]  = fft_d6;
  assign bins_in[7]  = fft_d7;
  assign bins_in[8]  = fft_d8;
  assign bins_in[9]  = fft_d9;
  assign bins_in[10] = fft_d10;
  assign bins_in[11] = fft_d11;
  assign bins_in[12] = fft_d12;
  assign bins_in[13] = fft_d13;
  assign bins_in[14] = fft_d14;
  assign bins_in[15] = fft_d15;

  // Select the bin under evaluation and split it into components.
  always_comb begin
    cur_bin = frame_q[idx_q];
    cur_re  = cur_bin[BIN_W-1:DATA_W];
    cur_im  = cur_bin[DATA_W-1:0];
  end

  fpd_mag_sq #(
    .DATA_W (DATA_W)
  ) u_mag_sq (
    .re_i  (cur_re),
    .im_i  (cur_im),
    .mag_o (cur_mag)
  );

  // With DC skipping, slot 0 still takes its cycle but never competes.
  assign cmp_en = !(SKIP_DC && (idx_q == '0));

  // Frame capture; contents only matter once a frame is accepted.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned k = 0; k < NUM_BINS; k++) begin
        frame_q[k] <= bins_in[k];
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      max_mag_q <= '0;
      max_idx_q <= '0;
      freq_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      max_mag_q <= max_mag_d;
      max_idx_q <= max_idx_d;
      freq_q    <= freq_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state, peak tracking and result/strobe generation.
  // done and freq are registered on the edge that leaves DONE, which is
  // what places the strobe 17 edges after the sampling edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    max_mag_d = max_mag_q;
    max_idx_d = max_idx_q;
    freq_d    = freq_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          load      = 1'b1;
          idx_d     = '0;
          max_mag_d = '0;
          max_idx_d = START_IDX;
          state_d   = CALC;
        end
      end

      CALC: begin
        if (fft_valid) begin
          ovf_d = 1'b1;
        end
        if (cmp_en && (cur_mag > max_mag_q)) begin
          max_mag_d = cur_mag;
          max_idx_d = idx_q;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_BINS - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        freq_d = max_idx_q;
        done_d = 1'b1;
        if (fft_valid) begin
          load      = 1'b1;
          idx_d     = '0;
          max_mag_d = '0;
          max_idx_d = START_IDX;
          state_d   = CALC;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign freq = freq_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect. A timeline model (accepted frame ->
// busy window, done 17 edges later with the arg-max of the captured frame,
// sticky overrun) is checked every cycle; literal expectations per scenario
// pin the model.
module tb_fft_peak_detect;
  import fpd_pkg::*;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] bin_v [16];
  logic [3:0]  freq;
  logic        done;
  logic        busy;
  logic        ovf;

  int tests;
  int fails;

`ifdef FPD_SKIP_DC_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  fft_peak_detect #(
    .DATA_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (bin_v[0]),
    .fft_d1    (bin_v[1]),
    .fft_d2    (bin_v[2]),
    .fft_d3    (bin_v[3]),
    .fft_d4    (bin_v[4]),
    .fft_d5    (bin_v[5]),
    .fft_d6    (bin_v[6]),
    .fft_d7    (bin_v[7]),
    .fft_d8    (bin_v[8]),
    .fft_d9    (bin_v[9]),
    .fft_d10   (bin_v[10]),
    .fft_d11   (bin_v[11]),
    .fft_d12   (bin_v[12]),
    .fft_d13   (bin_v[13]),
    .fft_d14   (bin_v[14]),
    .fft_d15   (bin_v[15]),
    .freq      (freq),
    .done      (done),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    logic [15:0] r;
    logic [15:0] i;
    r = re[15:0];
    i = im[15:0];
    bin_v[k] = {r, i};
  endtask

  task automatic set_all(input int re, input int im);
    for (int k = 0; k < 16; k++) set_bin(k, re, im);
  endtask

  // Arg-max of |bin|^2 with lowest-index tie break, from the driven bins.
  function automatic int model_peak();
    fpd_bin_t b;
    longint   best;
    longint   mag;
    int       bi;
    int       start;
    start = SKIP ? 1 : 0;
    best  = 0;
    bi    = start;
    for (int k = start; k < 16; k++) begin
      b   = fpd_unpack(bin_v[k]);
      mag = longint'(b.re) * longint'(b.re) + longint'(b.im) * longint'(b.im);
      if (mag > best) begin
        best = mag;
        bi   = k;
      end
    end
    return bi;
  endfunction

  // Timeline model and per-cycle comparison.
  int cyc;
  int acc_cyc;
  int pend;
  bit active;
  bit exp_done;
  bit exp_busy;
  bit exp_ovf;
  int exp_freq;

  initial begin
    cyc = 0; acc_cyc = 0; pend = 0; active = 0;
    exp_done = 0; exp_busy = 0; exp_ovf = 0; exp_freq = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      active   = 0;
      exp_done = 0;
      exp_busy = 0;
      exp_ovf  = 0;
      exp_freq = 0;
    end else begin
      exp_done = 0;
      if (active && cyc == acc_cyc + 17) begin
        exp_done = 1;
        exp_freq = pend;
        active   = 0;
      end
      if (fft_valid) begin
        if (active) exp_ovf = 1;
        else begin
          active  = 1;
          acc_cyc = cyc;
          pend    = model_peak();
        end
      end
      exp_busy = active;
    end
    #1;
    chk("cyc_done", done, exp_done);
    chk("cyc_busy", busy, exp_busy);
    chk("cyc_freq", freq, exp_freq);
    chk("cyc_ovf",  ovf,  exp_ovf);
  end

  // Pulse fft_valid for one sampling edge; returns just after that edge.
  task automatic send_frame();
    @(negedge clk);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
  endtask

  // Edges from the sampling edge until done is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1;
    end
    if (!got) lat = -1;
  endtask

  task automatic run_frame(input string name, input int exp_f);
    int lat;
    send_frame();
    wait_done(lat);
    chk({name, "_latency"}, lat, 17);
    chk({name, "_freq"}, freq, exp_f);
  endtask

  initial begin
    int lat;
    int ndone;
    rst       = 1'b0;
    fft_valid = 1'b0;
    set_all(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_freq", freq, 0);
    chk("reset_ovf",  ovf,  0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single tone.
    set_all(0, 0);
    set_bin(5, 1000, 0);
    run_frame("tone", 5);
    chk("tone_ovf", ovf, 0);

    // Tie between bins 3 and 9.
    set_all(1, 0);
    set_bin(3, 100, 100);
    set_bin(9, 100, 100);
    run_frame("tie", 3);

    // Extremes: 2^31 must beat 32767^2.
    set_all(32767, 0);
    set_bin(12, -32768, -32768);
    run_frame("extreme", 12);

    // DC dominant.
    set_all(0, 0);
    set_bin(0, 5000, 0);
    set_bin(7, 10, 0);
    run_frame("dc", SKIP ? 7 : 0);

    // All-zero frame.
    set_all(0, 0);
    run_frame("zero", SKIP ? 1 : 0);
    chk("pre_overrun_ovf", ovf, 0);

    // Overrun: second frame 5 cycles after the first is dropped.
    set_all(0, 0);
    set_bin(2, 300, 0);
    send_frame();
    repeat (4) @(posedge clk);
    set_all(0, 0);
    set_bin(9, 2000, 0);
    send_frame();
    wait_done(lat);
    chk("overrun_latency", lat, 12);
    chk("overrun_freq", freq, 2);
    chk("overrun_ovf", ovf, 1);

    // Third frame sampled during the done cycle is accepted.
    set_all(0, 0);
    set_bin(14, -500, 7);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    wait_done(lat);
    chk("b2b_latency", lat, 17);
    chk("b2b_freq", freq, 14);
    chk("b2b_ovf", ovf, 1);

    // Reset mid-CALC aborts the frame.
    set_all(0, 0);
    set_bin(6, 0, -900);
    send_frame();
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_freq", freq, 0);
    chk("abort_ovf",  ovf,  0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // Recovery after the abort.
    run_frame("recover", 6);
    chk("recover_ovf", ovf, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
